// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_seq_ctrl
//  Purpose  : Sequences an external up/down counter for a commanded number of
//             steps with wrap/bounce limit handling, pause and abort.
//  Revision : 1.0  initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int LEN_W  = 8,
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_bounce,
    input  logic              pause,
    input  logic              abort,
    input  logic [WIDTH-1:0]  cnt_value,
    output logic              cnt_en,
    output logic              cnt_up_down,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [WRAP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_dir;
    logic              r_bounce;
    logic [LEN_W-1:0]  r_rem;
    logic [WRAP_W-1:0] r_wrap;
    logic              r_aborted;

    logic              w_accept;
    logic              w_step;
    logic              w_abort_run;
    logic              w_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_abort_run = 1'b0;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cmd_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority: no step is issued in the abort cycle.
                if (abort) begin
                    w_abort_run = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (!pause) begin
                    w_step = 1'b1;
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Limit in the current travel direction: top when going up, zero when down.
    assign w_limit     = r_dir ? (cnt_value == {WIDTH{1'b1}}) : (cnt_value == '0);
    assign cnt_en      = w_step;
    assign cnt_up_down = (w_step && r_bounce && w_limit) ? ~r_dir : r_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir     <= 1'b1;
            r_bounce  <= 1'b0;
            r_rem     <= '0;
            r_wrap    <= '0;
            r_aborted <= 1'b0;
        end else if (w_accept) begin
            r_dir     <= cmd_dir;
            r_bounce  <= cmd_bounce;
            r_rem     <= cmd_len;
            r_wrap    <= '0;
            r_aborted <= 1'b0;
        end else if (w_abort_run) begin
            r_aborted <= 1'b1;
        end else if (w_step) begin
            if (r_rem != '0) begin
                r_rem <= r_rem - LEN_W'(1);
            end
            if (w_limit) begin
                if (r_bounce) begin
                    r_dir <= ~r_dir;
                end else if (r_wrap != {WRAP_W{1'b1}}) begin
                    r_wrap <= r_wrap + WRAP_W'(1);
                end
            end
        end
    end

    assign aborted  = r_aborted;
    assign wrap_cnt = r_wrap;

endmodule
`default_nettype wire
